// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants, instruction field positions and the redirect FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int IMM_W  = 16;
  localparam int TGT_W  = 26;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Word-aligned, sign-extended branch displacement in bytes.
  function automatic logic [31:0] branch_offset(input logic [31:0] instr);
    return {{(32 - IMM_W - 2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_ctrl.sv
// PC redirect producer: decodes J/JAL/BEQ/BNE, registers one-cycle redirect pulses to the PC,
// squashes wrong-path fetches after a taken redirect and keeps branch statistics.
module branch_ctrl
  import mips_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic [31:0]      instr_pc,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  output logic             zeroflag,
  output logic             jmpFlag,
  output logic             branchFlag,
  output logic [31:0]      jmpAddress,
  output logic [31:0]      branchOffset,
  output logic             squash,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

  // Handshake: instr_valid qualifies instr/instr_pc/rs_data/rt_data for one cycle; there is no
  // back-pressure, an instruction offered while the FSM is flushing is simply dropped.
  logic [5:0]      opcode;
  logic            is_jump;
  logic            is_branch;
  logic            take_branch;
  logic            accept;
  logic            redirect;
  logic [31:0]     pc_plus4;

  logic [0:0]      state_q, state_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            zeroflag_q, zeroflag_d;
  logic            jmp_flag_q, jmp_flag_d;
  logic            branch_flag_q, branch_flag_d;
  logic [31:0]     jmp_address_q, jmp_address_d;
  logic [31:0]     branch_offset_q, branch_offset_d;

  assign opcode      = instr[OPC_HI:OPC_LO];
  assign is_jump     = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign take_branch = (opcode == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
  assign accept      = instr_valid && (state_q == ST_RUN);
  assign redirect    = accept && (is_jump || (is_branch && take_branch));
  assign pc_plus4    = instr_pc + 32'd4;

  always_comb begin
    zeroflag_d      = 1'b1;
    jmp_flag_d      = 1'b0;
    branch_flag_d   = 1'b0;
    jmp_address_d   = '0;
    branch_offset_d = '0;
    if (accept && is_jump) begin
      jmp_flag_d    = 1'b1;
      jmp_address_d = {pc_plus4[31:28], instr[TGT_W-1:0], 2'b00};
    end else if (accept && is_branch) begin
      branch_flag_d   = 1'b1;
      zeroflag_d      = ~take_branch;
      branch_offset_d = branch_offset(instr);
    end
  end

  // The counter is loaded with the squash length and leaves FLUSH on the edge where it reads 1.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (redirect && (FLUSH_CYCLES > 0)) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      default: begin
        flush_cnt_d = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q == FC_W'(1)) state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_RUN;
      flush_cnt_q     <= '0;
      zeroflag_q      <= 1'b1;
      jmp_flag_q      <= 1'b0;
      branch_flag_q   <= 1'b0;
      jmp_address_q   <= '0;
      branch_offset_q <= '0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      zeroflag_q      <= zeroflag_d;
      jmp_flag_q      <= jmp_flag_d;
      branch_flag_q   <= branch_flag_d;
      jmp_address_q   <= jmp_address_d;
      branch_offset_q <= branch_offset_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (accept && is_branch),
    .cnt (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .cnt (taken_cnt)
  );

  assign zeroflag     = zeroflag_q;
  assign jmpFlag      = jmp_flag_q;
  assign branchFlag   = branch_flag_q;
  assign jmpAddress   = jmp_address_q;
  assign branchOffset = branch_offset_q;
  assign squash       = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: a squashing instance (FLUSH_CYCLES=2, CNT_W=4) and a non-squashing one
// (FLUSH_CYCLES=0, CNT_W=16) share stimulus and are checked against a cycle-level reference model.
module tb_branch_ctrl;

  localparam int OBS_W = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic [31:0] instr = '0, instr_pc = '0, rs_data = '0, rt_data = '0;

  logic zeroflag0, jmpFlag0, branchFlag0, squash0;
  logic [31:0] jmpAddress0, branchOffset0;
  logic [3:0] branch_cnt0, taken_cnt0;
  logic zeroflag1, jmpFlag1, branchFlag1, squash1;
  logic [31:0] jmpAddress1, branchOffset1;
  logic [15:0] branch_cnt1, taken_cnt1;

  logic [OBS_W-1:0] obs0, obs1;
  logic [OBS_W-1:0] exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: per instance, edges still to be ignored and the statistic counts.
  int          blk[2];
  logic [15:0] bc[2];
  logic [15:0] tc[2];
  int          fc_of[2]   = '{2, 0};
  int          cmax_of[2] = '{15, 65535};

  always #5 clk = ~clk;

  branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .rs_data(rs_data), .rt_data(rt_data), .zeroflag(zeroflag0), .jmpFlag(jmpFlag0),
    .branchFlag(branchFlag0), .jmpAddress(jmpAddress0), .branchOffset(branchOffset0),
    .squash(squash0), .branch_cnt(branch_cnt0), .taken_cnt(taken_cnt0)
  );

  branch_ctrl #(.FLUSH_CYCLES(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .rs_data(rs_data), .rt_data(rt_data), .zeroflag(zeroflag1), .jmpFlag(jmpFlag1),
    .branchFlag(branchFlag1), .jmpAddress(jmpAddress1), .branchOffset(branchOffset1),
    .squash(squash1), .branch_cnt(branch_cnt1), .taken_cnt(taken_cnt1)
  );

  assign obs0 = {zeroflag0, jmpFlag0, branchFlag0, squash0, jmpAddress0, branchOffset0,
                 12'h000, branch_cnt0, 12'h000, taken_cnt0};
  assign obs1 = {zeroflag1, jmpFlag1, branchFlag1, squash1, jmpAddress1, branchOffset1,
                 branch_cnt1, taken_cnt1};

  // Drive one cycle of inputs, clock it, advance the model, then settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] pc,
                      input logic [31:0] rs, input logic [31:0] rt, input logic r);
    logic [5:0] op;
    logic acc, take, zf, jf, bf;
    logic [31:0] ja, bo;
    logic signed [15:0] imm;
    instr_valid = v; instr = i; instr_pc = pc; rs_data = rs; rt_data = rt; rst = r;
    @(posedge clk);
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        blk[k] = 0; bc[k] = 0; tc[k] = 0;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 16'h0});
      end else begin
        op = i[31:26];
        acc = v && (blk[k] == 0);
        zf = 1'b1; jf = 1'b0; bf = 1'b0; ja = '0; bo = '0; take = 1'b0;
        if (acc && (op == 6'd2 || op == 6'd3)) begin
          jf = 1'b1; take = 1'b1;
          ja = ((pc + 32'd4) & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
        end else if (acc && (op == 6'd4 || op == 6'd5)) begin
          bf = 1'b1;
          take = (op == 6'd4) ? (rs == rt) : (rs != rt);
          zf = !take;
          imm = i[15:0];
          bo = 32'(int'(imm) * 4);
          if (int'(bc[k]) < cmax_of[k]) bc[k] = bc[k] + 16'd1;
        end
        if (take && int'(tc[k]) < cmax_of[k]) tc[k] = tc[k] + 16'd1;
        if (acc && take && fc_of[k] > 0) blk[k] = fc_of[k];
        else if (blk[k] > 0) blk[k] = blk[k] - 1;
        exp_q.push_back({zf, jf, bf, (blk[k] > 0), ja, bo, bc[k], tc[k]});
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({zeroflag0, jmpFlag0, branchFlag0, squash0, branch_cnt0, taken_cnt0} !== 12'h800) begin
      n_fail++;
      $display("FAIL reset_state0 got zf=%b jf=%b bf=%b sq=%b bc=%h tc=%h want zf=1 others 0",
               zeroflag0, jmpFlag0, branchFlag0, squash0, branch_cnt0, taken_cnt0);
    end
    n_cmp++;
    if (obs1 !== exp_q[1]) begin
      n_fail++; $display("FAIL reset_state1 got %h want %h", obs1, exp_q[1]);
    end
  endtask

  task automatic test_jump;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0800_0010, 32'h0000_0100, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if ({jmpFlag0, branchFlag0, squash0, jmpAddress0} !== {3'b101, 32'h0000_0040}) begin
      n_fail++;
      $display("FAIL jump_pulse got jf=%b bf=%b sq=%b addr=%h want jf=1 bf=0 sq=1 addr=00000040",
               jmpFlag0, branchFlag0, squash0, jmpAddress0);
    end
    // Redirecting instructions offered during the squash must be dropped by the flushing instance.
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 32'h1085_FFFE, 32'h0000_0104, 32'd3, 32'd3, 1'b0);
      n_cmp++;
      if ({jmpFlag0, branchFlag0, squash0} !== {2'b00, (c == 0)}) begin
        n_fail++;
        $display("FAIL jump_squash[%0d] got jf=%b bf=%b sq=%b want jf=0 bf=0 sq=%0d",
                 c, jmpFlag0, branchFlag0, squash0, (c == 0));
      end
      n_cmp++;
      if (obs1 !== exp_q[1]) begin
        n_fail++; $display("FAIL jump_noflush[%0d] got %h want %h", c, obs1, exp_q[1]);
      end
    end
  endtask

  task automatic test_beq_taken;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h1085_FFFE, 32'h0000_0200, 32'd7, 32'd7, 1'b0);
    n_cmp++;
    if ({branchFlag0, zeroflag0, branchOffset0, taken_cnt0} !== {2'b10, 32'hFFFF_FFF8, 4'd1}) begin
      n_fail++;
      $display("FAIL beq_taken got bf=%b zf=%b off=%h tc=%0d want bf=1 zf=0 off=fffffff8 tc=1",
               branchFlag0, zeroflag0, branchOffset0, taken_cnt0);
    end
    n_cmp++;
    if (obs0 !== exp_q[0]) begin
      n_fail++; $display("FAIL beq_taken_model got %h want %h", obs0, exp_q[0]);
    end
    idle(2);
  endtask

  task automatic test_bne_not_taken;
    step(1'b1, 32'h1485_0003, 32'h0000_0300, 32'd9, 32'd9, 1'b0);
    n_cmp++;
    if ({branchFlag0, zeroflag0, squash0, branchOffset0, branch_cnt0, taken_cnt0} !==
        {3'b110, 32'h0000_000C, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL bne_not_taken got bf=%b zf=%b sq=%b off=%h bc=%0d tc=%0d want 1 1 0 0000000c 2 1",
               branchFlag0, zeroflag0, squash0, branchOffset0, branch_cnt0, taken_cnt0);
    end
    idle(1);
    n_cmp++;
    if ({branchFlag0, zeroflag0} !== 2'b01) begin
      n_fail++;
      $display("FAIL bne_pulse_end got bf=%b zf=%b want bf=0 zf=1", branchFlag0, zeroflag0);
    end
  endtask

  task automatic test_reset_in_flush;
    step(1'b1, 32'h0800_0010, 32'h0000_0400, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0800_0010, 32'h0000_0404, 32'h0, 32'h0, 1'b1);
    n_cmp++;
    if ({squash0, jmpFlag0, taken_cnt0} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flush got sq=%b jf=%b tc=%0d want all 0", squash0, jmpFlag0, taken_cnt0);
    end
    step(1'b1, 32'h0800_0020, 32'h0000_0500, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if ({jmpFlag0, jmpAddress0} !== {1'b1, 32'h0000_0080}) begin
      n_fail++;
      $display("FAIL post_reset_accept got jf=%b addr=%h want jf=1 addr=00000080",
               jmpFlag0, jmpAddress0);
    end
    idle(2);
  endtask

  task automatic test_non_control;
    step(1'b1, 32'h0085_1020, 32'h0000_0600, 32'd1, 32'd2, 1'b0);
    n_cmp++;
    if ({zeroflag0, jmpFlag0, branchFlag0, jmpAddress0, branchOffset0} !== {3'b100, 64'h0}) begin
      n_fail++;
      $display("FAIL non_control got zf=%b jf=%b bf=%b ja=%h bo=%h want zf=1 rest 0",
               zeroflag0, jmpFlag0, branchFlag0, jmpAddress0, branchOffset0);
    end
  endtask

  task automatic test_back_to_back;
    step(1'b1, 32'h0C00_0001, 32'h1000_0000, 32'h0, 32'h0, 1'b0);
    step(1'b1, 32'h0800_0002, 32'h1000_0004, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if ({jmpFlag1, squash1, jmpAddress1, jmpFlag0} !== {2'b10, 32'h1000_0008, 1'b0}) begin
      n_fail++;
      $display("FAIL back_to_back got jf1=%b sq1=%b ja1=%h jf0=%b want 1 0 10000008 0",
               jmpFlag1, squash1, jmpAddress1, jmpFlag0);
    end
    idle(2);
  endtask

  task automatic test_saturation;
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 32'h1085_0004, 32'h0000_0700, 32'd5, 32'd5, 1'b0);
      idle(2);
    end
    n_cmp++;
    if ({branch_cnt0, taken_cnt0, branch_cnt1, taken_cnt1} !== {8'hFF, 16'd20, 16'd20}) begin
      n_fail++;
      $display("FAIL saturation got bc0=%h tc0=%h bc1=%0d tc1=%0d want f f 20 20",
               branch_cnt0, taken_cnt0, branch_cnt1, taken_cnt1);
    end
  endtask

  task automatic test_random;
    logic [31:0] i, rs, rt;
    logic [5:0] op;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h02;
        1: op = 6'h03;
        2: op = 6'h04;
        3: op = 6'h05;
        default: op = 6'($urandom_range(0, 63));
      endcase
      i = {op, 26'($urandom)};
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 1) ? rs : 32'($urandom);
      step(1'($urandom_range(0, 3) != 0), i, $urandom, rs, rt, ($urandom_range(0, 39) == 0));
      n_cmp++;
      if (obs0 !== exp_q[0]) begin
        n_fail++; $display("FAIL random0[%0d] got %h want %h", n, obs0, exp_q[0]);
      end
      n_cmp++;
      if (obs1 !== exp_q[1]) begin
        n_fail++; $display("FAIL random1[%0d] got %h want %h", n, obs1, exp_q[1]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin blk[k] = 0; bc[k] = 0; tc[k] = 0; end
    test_reset();
    test_jump();
    test_beq_taken();
    test_bne_not_taken();
    test_reset_in_flush();
    test_non_control();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
